// File: rtl/cpu_run_ctrl_pkg.sv
// ============================================================================
// cpu_run_pkg : shared types and constants for the mips run controller
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_e;

  localparam logic [31:0] PC_RESET = 32'h3000;
  localparam logic [4:0]  GRF_ZERO = 5'd0;

  // Rotate-left-by-one, then fold in the destination register and the data.
  function automatic logic [31:0] wb_sig_next(input logic [31:0] sig,
                                              input logic [4:0]  addr,
                                              input logic [31:0] data);
    return {sig[30:0], sig[31]} ^ {addr, 27'b0} ^ data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_run_cnt.sv
// ============================================================================
// run_cnt  : saturating up-counter with synchronous clear and enable
// Revision : 1.0
// ============================================================================
`default_nettype none

module run_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// cpu_run_ctrl : reset sequencer and run monitor for the pipelined mips core
//                (write-back signature enabled by CPU_RUN_CTRL_WB_SIG_EN)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RST_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 5,
  parameter int MAX_CYCLES   = 4096,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      pc_end,
  input  logic [31:0]      pc_i,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [31:0]      wb_sig
);

  localparam logic [63:0] MAX_M1 = 64'(MAX_CYCLES - 1);

  run_state_e  state_q, state_d;
  logic [31:0] phase_q, phase_d;
  logic [31:0] pc_end_q, pc_end_d;
  logic        core_reset_q, running_q, done_q, timeout_q;
  logic        in_run, budget_hit, retire, clr;

  assign in_run     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // A budget that does not fit in CNT_W can never match, so no timeout.
  assign budget_hit = in_run && (64'(cycle_cnt) == MAX_M1);
  assign retire     = in_run && wb_we && (wb_addr != GRF_ZERO);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pc_end_d = pc_end_q;
    clr      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d  = ST_RESET;
          phase_d  = '0;
          pc_end_d = pc_end;
          clr      = 1'b1;
        end
      end
      ST_RESET: begin
        if (phase_q == 32'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      ST_RUN: begin
        if (budget_hit) begin
          state_d = ST_TIMEOUT;
        end else if (pc_i >= pc_end_q) begin
          state_d = ST_DRAIN;
          phase_d = '0;
        end
      end
      ST_DRAIN: begin
        if (budget_hit) begin
          state_d = ST_TIMEOUT;
        end else if (phase_q == 32'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      pc_end_q     <= PC_RESET;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pc_end_q     <= pc_end_d;
      core_reset_q <= !((state_d == ST_RUN) || (state_d == ST_DRAIN));
      running_q    <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q       <= (state_d == ST_DONE);
      timeout_q    <= (state_d == ST_TIMEOUT);
    end
  end

  // The final edge into TIMEOUT does not count, leaving cycle_cnt at MAX_CYCLES-1.
  run_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (clr),
    .en_i  (in_run && !budget_hit),
    .cnt_o (cycle_cnt)
  );

  run_cnt #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (clr),
    .en_i  (retire),
    .cnt_o (retire_cnt)
  );

`ifdef CPU_RUN_CTRL_WB_SIG_EN
  logic [31:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (retire) begin
      sig_d = wb_sig_next(sig_q, wb_addr, wb_data);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign wb_sig = sig_q;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign wb_sig         = 32'h0;
`endif

  assign core_reset = core_reset_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// tb_cpu_run_ctrl : randomized scoreboard bench for cpu_run_ctrl
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

  localparam int RST_C   = 2;
  localparam int DRAIN_C = 5;
  localparam int MAX_C   = 16;
  localparam int NK      = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_end = 32'h0;
  logic [31:0] pc_i = 32'h3000;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        core_reset, running, done, timeout;
  logic [31:0] cycle_cnt, retire_cnt, wb_sig;

  cpu_run_ctrl #(
    .RST_CYCLES   (RST_C),
    .DRAIN_CYCLES (DRAIN_C),
    .MAX_CYCLES   (MAX_C),
    .CNT_W        (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc_end     (pc_end),
    .pc_i       (pc_i),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .core_reset (core_reset),
    .running    (running),
    .done       (done),
    .timeout    (timeout),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt),
    .wb_sig     (wb_sig)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          to;
    int          cyc;
    int          ret;
    logic [31:0] sig;
  } exp_t;

  exp_t sb[$];
  exp_t em;
  bit   flag_prev = 1'b0;

  // One entry per run cycle k (k = 0 is the first cycle the core is out of reset).
  logic [31:0] pc_a[NK];
  bit          we_a[NK];
  logic [4:0]  ad_a[NK];
  logic [31:0] da_a[NK];
  bit          st_a[NK];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: walk the run cycle by cycle using the behavioural rules.
  function automatic exp_t model(input logic [31:0] pe);
    exp_t e;
    int   det;
    det   = -1;
    e.to  = 1'b0;
    e.cyc = 0;
    e.ret = 0;
    e.sig = 32'h0;
    for (int k = 0; k < NK; k++) begin
      if (we_a[k] && ad_a[k] != 5'd0) begin
        e.ret = e.ret + 1;
`ifdef CPU_RUN_CTRL_WB_SIG_EN
        e.sig = {e.sig[30:0], e.sig[31]} ^ {ad_a[k], 27'b0} ^ da_a[k];
`endif
      end
      if (k == MAX_C - 1) begin
        e.to  = 1'b1;
        e.cyc = k;
        return e;
      end
      if (det >= 0 && k == det + DRAIN_C) begin
        e.cyc = k + 1;
        return e;
      end
      if (det < 0 && pc_a[k] >= pe) det = k;
    end
    return e;
  endfunction

  function automatic void clear_prog(input logic [31:0] pc);
    for (int k = 0; k < NK; k++) begin
      pc_a[k] = pc;
      we_a[k] = 1'b0;
      ad_a[k] = 5'd0;
      da_a[k] = 32'h0;
      st_a[k] = 1'b0;
    end
  endfunction

  task automatic gen_random(output logic [31:0] pe);
    int          n;
    logic [31:0] cur;
    bit          reached;
    n       = int'($urandom_range(1, 12));
    pe      = 32'h3000 + 32'(4 * n);
    cur     = 32'h3000;
    reached = 1'b0;
    for (int k = 0; k < NK; k++) begin
      pc_a[k] = reached ? 32'h3000 + 32'(4 * $urandom_range(0, n + 2)) : cur;
      if (pc_a[k] >= pe) reached = 1'b1;
      if ($urandom_range(0, 9) < 7) cur = cur + 32'd4;
      we_a[k] = ($urandom_range(0, 1) == 1);
      ad_a[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      da_a[k] = $urandom;
      st_a[k] = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_running"}, 64'(running), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    chk({tag, "_retire_cnt"}, 64'(retire_cnt), 64'd0);
    chk({tag, "_wb_sig"}, 64'(wb_sig), 64'd0);
  endtask

  // Called at posedge+1. abort_k >= 0 pulls the async reset during run cycle abort_k.
  task automatic do_run(input logic [31:0] pe, input int abort_k);
    exp_t e;
    int   klast;
    e     = model(pe);
    klast = e.to ? e.cyc : e.cyc - 1;
    if (abort_k < 0) sb.push_back(e);
    start  = 1'b1;
    pc_end = pe;
    @(posedge clk); #1;
    start   = 1'b0;
    pc_end  = $urandom;
    pc_i    = pe;
    wb_we   = 1'b1;
    wb_addr = 5'($urandom_range(1, 31));
    wb_data = $urandom;
    chk("start_core_reset", 64'(core_reset), 64'd1);
    chk("start_running", 64'(running), 64'd0);
    chk("start_cycle_clr", 64'(cycle_cnt), 64'd0);
    chk("start_retire_clr", 64'(retire_cnt), 64'd0);
    chk("start_sig_clr", 64'(wb_sig), 64'd0);
    for (int i = 1; i <= RST_C; i++) begin
      @(posedge clk); #1;
      if (i < RST_C) begin
        chk("reset_hold_core_reset", 64'(core_reset), 64'd1);
        chk("reset_hold_running", 64'(running), 64'd0);
      end else begin
        chk("run_entry_core_reset", 64'(core_reset), 64'd0);
        chk("run_entry_running", 64'(running), 64'd1);
        chk("run_entry_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("run_entry_retire_cnt", 64'(retire_cnt), 64'd0);
      end
    end
    for (int k = 0; k < NK; k++) begin
      pc_i    = pc_a[k];
      wb_we   = we_a[k];
      wb_addr = ad_a[k];
      wb_data = da_a[k];
      start   = st_a[k] && (k <= klast);
      if (k == abort_k) begin
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        @(posedge clk); #1;
        chk("async_hold_core_reset", 64'(core_reset), 64'd1);
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("post_async_idle");
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    wb_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if ((done || timeout) && !flag_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_end: done=%0b timeout=%0b with no run outstanding", done, timeout);
      end else begin
        em = sb.pop_front();
        chk("end_timeout", 64'(timeout), 64'(em.to));
        chk("end_done", 64'(done), 64'(!em.to));
        chk("end_cycle_cnt", 64'(cycle_cnt), 64'(em.cyc));
        chk("end_retire_cnt", 64'(retire_cnt), 64'(em.ret));
        chk("end_wb_sig", 64'(wb_sig), 64'(em.sig));
        chk("end_core_reset", 64'(core_reset), 64'd1);
        chk("end_running", 64'(running), 64'd0);
      end
    end
    flag_prev = done || timeout;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d runs outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pe;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("idle");

    // Normal end: four instructions, $1..$3 written.
    clear_prog(32'h300C);
    pc_a[0] = 32'h3000; pc_a[1] = 32'h3004; pc_a[2] = 32'h3008;
    for (int k = 1; k <= 3; k++) begin
      we_a[k] = 1'b1;
      ad_a[k] = 5'(k);
      da_a[k] = $urandom;
    end
    do_run(32'h300C, -1);
    // Restart from DONE with the same program, spurious start during RUN.
    st_a[1] = 1'b1;
    do_run(32'h300C, -1);

    // $0 writes must be invisible.
    clear_prog(32'h3018);
    for (int k = 0; k < 6; k++) pc_a[k] = 32'h3000 + 32'(4 * k);
    for (int k = 0; k < 3; k++) begin
      we_a[k] = 1'b1;
      ad_a[k] = 5'd0;
      da_a[k] = $urandom;
    end
    we_a[3] = 1'b1; ad_a[3] = 5'd5; da_a[3] = 32'hDEADBEEF;
    do_run(32'h3018, -1);

    // PC stuck: budget runs out.
    clear_prog(32'h3000);
    we_a[4] = 1'b1; ad_a[4] = 5'd7; da_a[4] = 32'h1234;
    do_run(32'h300C, -1);

    // End-PC detect on the same edge as the budget limit.
    clear_prog(32'h3000);
    pc_a[15] = 32'h3010;
    do_run(32'h3010, -1);

    // Drain completion on the same edge as the budget limit.
    clear_prog(32'h3000);
    for (int k = 10; k < NK; k++) pc_a[k] = 32'h3010;
    do_run(32'h3010, -1);

    // Async reset while draining.
    clear_prog(32'h300C);
    pc_a[0] = 32'h3000; pc_a[1] = 32'h3004; pc_a[2] = 32'h3008;
    we_a[1] = 1'b1; ad_a[1] = 5'd1; da_a[1] = 32'h55;
    do_run(32'h300C, 6);

    for (int r = 0; r < 40; r++) begin
      gen_random(pe);
      do_run(pe, -1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
